// File: rtl/uart_tx.sv
// uart_tx -- standalone UART transmitter.
//
// Sends one byte per handshake as an LSB-first frame: start bit (0),
// eight data bits, an optional parity bit, then one or two stop bits (1).
//
// Parameters:
//   FREQ       input clock frequency in Hz
//   BAUDRATE   line rate in bits per second; bit period DIV = FREQ / BAUDRATE
//   PARITY     0 = none, 1 = odd, 2 = even
//   STOP_BITS  1 or 2
//
// Ports:
//   clk_i    system clock, rising edge
//   rst_n_i  asynchronous active-low reset
//   nd_i     new data; data_i is valid while high
//   data_i   byte to transmit
//   rfd_o    ready for data; a byte is accepted on a rising edge with nd_i & rfd_o
//   busy_o   high while a frame is on the line (always the inverse of rfd_o)
//   txd_o    registered serial output, idle high
//
// Handshake: a byte is accepted on every rising clk_i edge where nd_i and
// rfd_o are both high. data_i is sampled only on that edge; nd_i while rfd_o
// is low is ignored. After the accept edge the frame starts immediately:
// txd_o, rfd_o and busy_o all change in the cycle following the accept edge.
module uart_tx #(
  parameter int FREQ      = 50000000,
  parameter int BAUDRATE  = 115200,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       nd_i,
  input  logic [7:0] data_i,
  output logic       rfd_o,
  output logic       busy_o,
  output logic       txd_o
);

  localparam int DIV = FREQ / BAUDRATE;
  localparam int CW  = (DIV >= 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  generate
    if (DIV < 2) begin : g_bad_div
      $error("uart_tx: FREQ / BAUDRATE must be at least 2");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_tx: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    sh, sh_n;
  logic          par_bit, par_n;
  logic          stop_idx, stop_n;
  logic          txd_n;
  logic          bit_done;

  // State is the sole source of the handshake outputs, so they are always
  // complementary and have no path from the inputs.
  assign rfd_o  = (state == S_IDLE);
  assign busy_o = (state != S_IDLE);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= S_IDLE;
      cnt      <= '0;
      idx      <= '0;
      sh       <= '0;
      par_bit  <= 1'b0;
      stop_idx <= 1'b0;
      txd_o    <= 1'b1;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      sh       <= sh_n;
      par_bit  <= par_n;
      stop_idx <= stop_n;
      txd_o    <= txd_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    sh_n     = sh;
    par_n    = par_bit;
    stop_n   = stop_idx;
    txd_n    = 1'b1;
    bit_done = (cnt == CNT_LAST);

    // The bit-period counter only runs inside a frame, so every frame is
    // phase-aligned to its accept edge.
    if (state == S_IDLE) begin
      cnt_n = '0;
    end else begin
      cnt_n = bit_done ? '0 : cnt + CW'(1);
    end

    case (state)
      S_IDLE: begin
        if (nd_i) begin
          sh_n    = data_i;
          par_n   = (PARITY == 1) ? ~^data_i : ^data_i;
          idx_n   = '0;
          stop_n  = 1'b0;
          state_n = S_START;
        end
      end
      S_START: begin
        if (bit_done) state_n = S_DATA;
      end
      S_DATA: begin
        if (bit_done) begin
          sh_n  = {1'b0, sh[7:1]};
          idx_n = idx + 3'd1;
          if (idx == 3'd7) state_n = (PARITY != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (bit_done) state_n = S_STOP;
      end
      S_STOP: begin
        if (bit_done) begin
          if ((STOP_BITS == 1) || (stop_idx == 1'b1)) state_n = S_IDLE;
          else stop_n = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // txd_o is registered from the next-state view so the line level lines up
    // with the state it belongs to, with no extra cycle of delay.
    case (state_n)
      S_START:  txd_n = 1'b0;
      S_DATA:   txd_n = sh_n[0];
      S_PARITY: txd_n = par_n;
      default:  txd_n = 1'b1;
    endcase
  end

endmodule
